// File: rtl/downscale_ctrl.sv
// Frame downscaler controller: 1:1 copy (zoom 2) or 2x2 block average (zoom 1)
// between a 1-cycle-latency source RAM and a ready-gated destination. Macro BLOCK_AVG_ROUND_EN selects round-half-up averaging.
module downscale_ctrl #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  zoom_level,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [14:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ready
);
    localparam int unsigned AW    = 15;
    localparam int unsigned DW    = 8;
    localparam int unsigned ACC_W = 10;
    localparam int unsigned XW    = $clog2(IMG_W);
    localparam int unsigned YW    = $clog2(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t            state, state_d;
    logic              mode_avg, mode_d;
    logic [XW-1:0]     xo, xo_d, wo_last;
    logic [YW-1:0]     yo, yo_d, ho_last;
    logic [1:0]        tap, tap_d, last_tap;
    logic [ACC_W-1:0]  acc, acc_d, acc_total;
    logic              rd_vld;
    logic              wr_first;
    logic [DW-1:0]     wr_hold, wr_hold_d, avg_c;
    logic              err_d;
    logic              zoom_ok, last_x, last_y;
    logic [AW-1:0]     row_c, col_c, wo_c, rd_addr_c, wr_addr_c;

    assign zoom_ok  = (zoom_level == 3'd1) || (zoom_level == 3'd2);
    assign last_tap = mode_avg ? 2'd3 : 2'd0;
    assign wo_last  = mode_avg ? XW'(IMG_W / 2 - 1) : XW'(IMG_W - 1);
    assign ho_last  = mode_avg ? YW'(IMG_H / 2 - 1) : YW'(IMG_H - 1);
    assign last_x   = (xo == wo_last);
    assign last_y   = (yo == ho_last);

    // rd_data belongs to the tap issued in the previous cycle
    assign acc_total = acc + (rd_vld ? ACC_W'(rd_data) : ACC_W'(0));

`ifdef BLOCK_AVG_ROUND_EN
    assign avg_c = mode_avg ? DW'((acc_total + ACC_W'(2)) >> 2) : DW'(acc_total);
`else
    assign avg_c = mode_avg ? DW'(acc_total >> 2) : DW'(acc_total);
`endif

    // The last tap lands in the first WRITE cycle, so that cycle forwards it; stalls then replay the held copy
    assign wr_data = wr_first ? avg_c : wr_hold;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            mode_avg <= 1'b0;
            xo       <= '0;
            yo       <= '0;
            tap      <= '0;
            acc      <= '0;
            rd_vld   <= 1'b0;
            wr_first <= 1'b0;
            wr_hold  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
        end else begin
            state    <= state_d;
            mode_avg <= mode_d;
            xo       <= xo_d;
            yo       <= yo_d;
            tap      <= tap_d;
            acc      <= acc_d;
            rd_vld   <= rd_en;
            wr_first <= (state_d == S_WRITE) && (state != S_WRITE);
            wr_hold  <= wr_hold_d;
            busy     <= (state_d != S_IDLE);
            done     <= (state_d == S_DONE);
            err      <= err_d;
            rd_en    <= (state_d == S_READ);
            wr_en    <= (state_d == S_WRITE);
            if (state_d == S_READ)  rd_addr <= rd_addr_c;
            if (state_d == S_WRITE) wr_addr <= wr_addr_c;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start && zoom_ok) state_d = S_READ;
            S_READ:  if (tap == last_tap) state_d = S_WRITE;
            S_WRITE: if (wr_ready) state_d = (last_x && last_y) ? S_DONE : S_READ;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        mode_d    = mode_avg;
        xo_d      = xo;
        yo_d      = yo;
        tap_d     = tap;
        acc_d     = rd_vld ? acc_total : acc;
        wr_hold_d = wr_hold;
        err_d     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (zoom_ok) begin
                        mode_d = (zoom_level == 3'd1);
                        xo_d   = '0;
                        yo_d   = '0;
                        tap_d  = '0;
                        acc_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: tap_d = (tap == last_tap) ? 2'd0 : tap + 2'd1;
            S_WRITE: begin
                if (wr_first) wr_hold_d = avg_c;
                if (wr_ready) begin
                    acc_d = '0;
                    if (last_x) begin
                        xo_d = '0;
                        yo_d = yo + YW'(1);
                    end else begin
                        xo_d = xo + XW'(1);
                    end
                end
            end
            default: ;
        endcase

        row_c     = mode_d ? AW'({yo_d, 1'b0}) + AW'(tap_d[1]) : AW'(yo_d);
        col_c     = mode_d ? AW'({xo_d, 1'b0}) + AW'(tap_d[0]) : AW'(xo_d);
        rd_addr_c = row_c * AW'(IMG_W) + col_c;
        wo_c      = mode_d ? AW'(IMG_W / 2) : AW'(IMG_W);
        wr_addr_c = AW'(yo_d) * wo_c + AW'(xo_d);
    end
endmodule

// File: doc/downscale_ctrl.md
DOWNSCALE_CTRL -- requirements
Module: downscale_ctrl

Interface
REQ-001 Parameter IMG_W, default 160: source image width in pixels.
REQ-002 Parameter IMG_H, default 120: source image height in pixels.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to process one frame; sampled only in IDLE.
REQ-006 zoom_level  input  3  2 = 1:1 copy; 1 = 2x2 block average; sampled with start.
REQ-007 busy  output  1  high from the cycle after accepted start until the DONE state is left.
REQ-008 done  output  1  one-cycle pulse when the last output pixel is written.
REQ-009 err  output  1  one-cycle pulse when start arrives with an unsupported zoom_level.
REQ-010 rd_en  output  1  source-RAM read strobe.
REQ-011 rd_addr  output  15  source address = y*IMG_W + x.
REQ-012 rd_data  input  8  source pixel, valid exactly one cycle after rd_en.
REQ-013 wr_en  output  1  destination write request.
REQ-014 wr_addr  output  15  destination address = yo*WO + xo.
REQ-015 wr_data  output  8  destination pixel.
REQ-016 wr_ready  input  1  destination accepts the write in any cycle where wr_en and wr_ready are both high.

Function
REQ-017 States: IDLE, READ, WRITE, DONE.
REQ-018 IDLE + start + zoom_level in {1,2}: latch mode; clear xo, yo, tap, acc; go to READ.
REQ-019 IDLE + start + other zoom_level: pulse err next cycle; stay in IDLE.
REQ-020 Output size: mode 2 gives WO=IMG_W, HO=IMG_H; mode 1 gives WO=IMG_W/2, HO=IMG_H/2.
REQ-021 READ issues N taps on N consecutive cycles with rd_en=1: N=1 (mode 2), N=4 (mode 1).
REQ-022 Tap order for mode 1: (2xo,2yo), (2xo+1,2yo), (2xo,2yo+1), (2xo+1,2yo+1); mode 2: (xo,yo).
REQ-023 Each cycle after a tap issue, rd_data is added to a 10-bit acc; the final tap's data is added in the first WRITE cycle.
REQ-024 After the last tap, go to WRITE; WRITE holds wr_en=1 with wr_addr and wr_data stable until wr_ready=1.
REQ-025 wr_data = acc_total >> 2 (mode 1) or rd_data captured from the single tap (mode 2); it is registered so that stalls do not alter it.
REQ-026 On write acceptance: clear acc; advance xo; at xo=WO-1, wrap xo to 0 and increment yo; at (WO-1, HO-1), go to DONE; otherwise go to READ.
REQ-027 Throughput with wr_ready tied high: 5 cycles/pixel in mode 1, 2 cycles/pixel in mode 2.
REQ-028 DONE: done=1 for one cycle; return to IDLE.
REQ-029 start outside IDLE is ignored, with no effect on the current frame.
REQ-030 rd_en=0 and wr_en=0 in IDLE and DONE; rd_en and wr_en are never high in the same cycle.
REQ-031 Address arithmetic is unsigned and exact; maximum rd_addr is IMG_W*IMG_H-1 (19199 by default), which fits in 15 bits.

Reset
REQ-032 reset asserted forces IDLE immediately, mid-frame included; the frame is abandoned and not resumed.
REQ-033 Reset values: busy, done, err, rd_en and wr_en are 0; rd_addr, wr_addr, wr_data, acc, xo, yo and tap are 0.

Configuration
REQ-034 Macro BLOCK_AVG_ROUND_EN defined: mode 1 wr_data = (acc_total + 2) >> 2, round-half-up; the result is at most 255 because acc_total is at most 1020.
REQ-035 Macro BLOCK_AVG_ROUND_EN undefined: mode 1 wr_data = acc_total >> 2, truncation; mode 2 is unaffected either way.

Verification
REQ-036 Mode 1, RAM all 8'd10, wr_ready=1: 4800 writes, all wr_data=10; done exactly once, 24000 cycles after busy rises.
REQ-037 Mode 1, taps 1,2,2,2 at block (0,0): wr_addr 0 gets wr_data=1 without the macro, 2 with it; first-pixel rd_addr sequence is 0, 1, 160, 161.
REQ-038 Mode 2, RAM[a]=a[7:0]: writes 0..19199 in order with wr_data=addr[7:0]; done after 38400 cycles.
REQ-039 Mode 1, wr_ready low for 7 cycles on the first write: wr_en, wr_addr and wr_data are held stable; no new rd_en; the flow resumes after acceptance.
REQ-040 zoom_level=3 with start: err pulses once; busy stays 0. A start issued mid-frame is ignored.
REQ-041 reset asserted mid-frame in mode 1: all outputs are 0 in the same cycle; a new start then produces a full frame beginning at wr_addr 0.
